max_pool_2x2_stream: RTL and testbench
======================================

// Module: max_pool_2x2_stream
// PURPOSE
//   Streaming 2x2/stride-2 signed max-pool, directly downstream of the 9->8 bit requantize stage.
//   Consumes one raster-ordered vector of SIZE signed 8-bit lanes per valid cycle.
//   Emits one pooled vector per 2x2 window, with no backpressure.
//   Output feeds the next conv layer's window/line-buffer stage.
// PARAMETERS
//   SIZE        4  number of parallel 8-bit lanes (channels) per beat
//   IMG_WIDTH   8  input pixels per row; must be even, >=2
//   IMG_HEIGHT  8  input rows per frame; must be even, >=2
// PORTS
//   clock            in   1       rising-edge clock
//   reset            in   1       asynchronous, active-low reset
//   pixel_in         in   8*SIZE  lane i = pixel_in[8*i+7:8*i], two's complement
//   pixel_in_valid   in   1       pixel_in is a frame pixel this cycle
//   pixel_out        out  8*SIZE  pooled vector, same lane packing
//   pixel_out_valid  out  1       pixel_out valid, single-cycle pulse
//   frame_done       out  1       pulses with the last pooled vector of a frame
// BEHAVIOUR
//   Reset (reset==0, async): col, row, h_reg, pixel_out, pixel_out_valid and frame_done all go to 0.
//     line_buf is not cleared; even rows overwrite it before any read.
//   Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 advance only on pixel_in_valid.
//     On col==W-1, col wraps to 0 and row increments.
//     On the last pixel of a frame, both wrap to 0.
//     With pixel_in_valid low, all state holds; gaps of any length are legal.
//   Per valid beat, per lane (signed compare, independent lanes):
//     even col:           h_reg <= pixel_in.
//     odd col:            hmax = max(h_reg, pixel_in).
//     odd col, even row:  line_buf[col>>1] <= hmax (IMG_WIDTH/2 entries x 8*SIZE bits).
//     odd col, odd row:   pixel_out <= max(line_buf[col>>1], hmax); pixel_out_valid <= 1.
//   Latency: pixel_out_valid is asserted on the cycle after the bottom-right pixel of each window.
//     All other cycles: pixel_out_valid <= 0; pixel_out holds its last value.
//   frame_done <= 1 together with the output of window (row H-1, col W-1); otherwise 0.
//   Throughput: one window output per 4 inputs; IMG_WIDTH*IMG_HEIGHT/4 outputs per frame.
//   Ties: output equals the tied value. Extremes: 8'h80 (-128) < 8'hFF (-1) < 8'h00 < 8'h7F (+127).
//   Reset mid-frame: the partial frame is discarded; the next valid beat is treated as pixel (0,0).
//   Back-to-back frames need no idle cycle; pixel (0,0) of frame N+1 may follow frame N's last pixel.
// TESTING
//   1. SIZE=1, W=H=4, continuous valid, pixel=r*4+c (0..15)
//      -> outputs 5,7,13,15; valid 1 cycle after inputs 5,7,13,15; frame_done with 15.
//   2. Signed window, lane0 inputs {0x80,0x81 / 0xFF,0x01}
//      -> 0x01. Same test with {0x80,0x80 / 0x80,0x80} -> 0x80.
//   3. SIZE=4, lane i = test1 data + 16*i
//      -> lane i outputs {5,7,13,15}+16*i; lanes never cross-contaminate.
//   4. Test 1 data with pixel_in_valid randomly low ~50% of cycles
//      -> identical output sequence; each valid is 1 cycle after its closing input.
//   5. Two back-to-back frames, second frame = first + 0x20
//      -> 8 outputs total; frame_done pulses twice; second set = 0x25,0x27,0x2D,0x2F.
//   6. Assert reset after 6 valid beats, release, then send test 1 frame
//      -> outputs/valid/frame_done are 0 during reset; then exactly 5,7,13,15.

Source files
------------

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2/stride-2 signed max-pool over SIZE independent 8-bit lanes.
// Row pairs are reduced horizontally, then vertically against a half-row line buffer.

module max_pool_lane (
    input  logic [7:0] h_reg,
    input  logic [7:0] pix,
    input  logic [7:0] lb,
    output logic [7:0] hmax,
    output logic [7:0] vmax
);
    always_comb begin
        hmax = ($signed(pix) > $signed(h_reg)) ? pix : h_reg;
        vmax = ($signed(lb) > $signed(hmax)) ? lb : hmax;
    end
endmodule

module max_pool_2x2_stream #(
    parameter int SIZE       = 4,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [8*SIZE-1:0] pixel_in,
    input  logic              pixel_in_valid,
    output logic [8*SIZE-1:0] pixel_out,
    output logic              pixel_out_valid,
    output logic              frame_done
);
    localparam int HW = IMG_WIDTH / 2;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int BW = (HW > 1) ? $clog2(HW) : 1;

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [8*SIZE-1:0]   h_reg_q, h_reg_d;
    logic [8*SIZE-1:0]   pixel_out_q, pixel_out_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [8*SIZE-1:0]   line_buf_q [HW];
    logic [BW-1:0]       lb_addr;
    logic                lb_we;
    logic [8*SIZE-1:0]   hmax, vmax;
    logic                last_col, last_row;

    assign lb_addr = BW'(col_q >> 1);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        max_pool_lane u_lane (
            .h_reg (h_reg_q[8*i +: 8]),
            .pix   (pixel_in[8*i +: 8]),
            .lb    (line_buf_q[lb_addr][8*i +: 8]),
            .hmax  (hmax[8*i +: 8]),
            .vmax  (vmax[8*i +: 8])
        );
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_reg_d      = h_reg_q;
        pixel_out_d  = pixel_out_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        last_col     = (col_q == CW'(IMG_WIDTH - 1));
        last_row     = (row_q == RW'(IMG_HEIGHT - 1));
        if (pixel_in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (!col_q[0]) begin
                h_reg_d = pixel_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                // Odd row, odd col closes a window: top half comes from the line buffer.
                pixel_out_d  = vmax;
                out_valid_d  = 1'b1;
                frame_done_d = last_col && last_row;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            h_reg_q      <= '0;
            pixel_out_q  <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_reg_q      <= h_reg_d;
            pixel_out_q  <= pixel_out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Not reset: every even row rewrites all entries before the odd row reads them.
    always_ff @(posedge clock) begin
        if (lb_we) line_buf_q[lb_addr] <= hmax;
    end

    assign pixel_out       = pixel_out_q;
    assign pixel_out_valid = out_valid_q;
    assign frame_done      = frame_done_q;
endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Bench for max_pool_2x2_stream: window-max model plus per-cycle compare,
// with literal checks on the pooled values of the directed frames.
`timescale 1ns/1ps
module tb_max_pool_2x2_stream;
    localparam int SIZE = 4;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [8*SIZE-1:0] pixel_in = '0;
    logic              pixel_in_valid = 1'b0;
    logic [8*SIZE-1:0] pixel_out;
    logic              pixel_out_valid;
    logic              frame_done;

    max_pool_2x2_stream #(.SIZE(SIZE), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock           (clock),
        .reset           (reset),
        .pixel_in        (pixel_in),
        .pixel_in_valid  (pixel_in_valid),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .frame_done      (frame_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    logic [7:0]        fr [NPIX][SIZE];
    logic [8*SIZE-1:0] exp_q [$];
    logic              expd_q [$];
    logic [8*SIZE-1:0] log_q [$];
    logic              drv_close = 1'b0;
    logic              exp_vld = 1'b0;
    logic [8*SIZE-1:0] last_out = '0;
    int                done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [8*SIZE-1:0] pix(input int p);
        logic [8*SIZE-1:0] v;
        for (int l = 0; l < SIZE; l++) v[8*l +: 8] = fr[p][l];
        return v;
    endfunction

    // Signed maximum of the four pixels of the window whose bottom-right is (r,c).
    function automatic logic [8*SIZE-1:0] win_max(input int r, input int c);
        logic [8*SIZE-1:0] v;
        int m, x;
        for (int l = 0; l < SIZE; l++) begin
            m = -1000;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    x = int'($signed(fr[(r - dr) * W + (c - dc)][l]));
                    if (x > m) m = x;
                end
            v[8*l +: 8] = 8'(m);
        end
        return v;
    endfunction

    function automatic logic [8*SIZE-1:0] lit(input int base);
        logic [8*SIZE-1:0] v;
        for (int l = 0; l < SIZE; l++) v[8*l +: 8] = 8'(base + 16 * l);
        return v;
    endfunction

    task automatic base_frame(input int add);
        for (int p = 0; p < NPIX; p++)
            for (int l = 0; l < SIZE; l++) fr[p][l] = 8'(p + 16 * l + add);
    endtask

    task automatic idle();
        @(posedge clock); #1;
        pixel_in_valid = 1'b0;
        drv_close      = 1'b0;
    endtask

    task automatic beat(input int p);
        int r, c;
        @(posedge clock); #1;
        r = p / W;
        c = p % W;
        pixel_in       = pix(p);
        pixel_in_valid = 1'b1;
        drv_close      = (r % 2 == 1) && (c % 2 == 1);
        if (drv_close) begin
            exp_q.push_back(win_max(r, c));
            expd_q.push_back((r == H - 1) && (c == W - 1));
        end
    endtask

    task automatic send(input int nbeats, input bit gaps);
        for (int p = 0; p < nbeats; p++) begin
            if (gaps)
                for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) idle();
            beat(p);
        end
    endtask

    task automatic drain(input string name);
        repeat (3) idle();
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            exp_vld  = 1'b0;
            last_out = '0;
        end else begin
            check("out_valid", 64'(pixel_out_valid), 64'(exp_vld));
            if (exp_vld && exp_q.size() > 0) begin
                check("out_data", 64'(pixel_out), 64'(exp_q[0]));
                check("frame_done", 64'(frame_done), 64'(expd_q[0]));
                void'(exp_q.pop_front());
                void'(expd_q.pop_front());
                last_out = pixel_out;
                log_q.push_back(pixel_out);
                if (frame_done) done_cnt++;
            end else if (!exp_vld) begin
                check("hold_data", 64'(pixel_out), 64'(last_out));
                check("done_idle", 64'(frame_done), 64'd0);
            end
            exp_vld = drv_close && pixel_in_valid;
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_out", 64'(pixel_out), 64'd0);
        check("rst_vld", 64'(pixel_out_valid), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Ramp frame, lane i offset by 16*i.
        base_frame(0);
        log_q.delete();
        send(NPIX, 1'b0);
        drain("t1");
        check("t1_n", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            check("t1_o0", 64'(log_q[0]), 64'(lit(5)));
            check("t1_o1", 64'(log_q[1]), 64'(lit(7)));
            check("t1_o2", 64'(log_q[2]), 64'(lit(13)));
            check("t1_o3", 64'(log_q[3]), 64'(lit(15)));
        end

        // Signed extremes and ties in lane 0.
        base_frame(0);
        fr[0][0] = 8'h80; fr[1][0] = 8'h81; fr[4][0] = 8'hFF; fr[5][0] = 8'h01;
        fr[2][0] = 8'h80; fr[3][0] = 8'h80; fr[6][0] = 8'h80; fr[7][0] = 8'h80;
        log_q.delete();
        send(NPIX, 1'b0);
        drain("t2");
        if (log_q.size() == 4) begin
            check("t2_mixed", 64'(log_q[0][7:0]), 64'h01);
            check("t2_tie", 64'(log_q[1][7:0]), 64'h80);
            check("t2_lane1", 64'(log_q[0][15:8]), 64'd21);
        end else check("t2_n", 64'(log_q.size()), 64'd4);

        // Random gaps on the input stream.
        base_frame(0);
        log_q.delete();
        send(NPIX, 1'b1);
        drain("t4");
        if (log_q.size() == 4) check("t4_o3", 64'(log_q[3]), 64'(lit(15)));
        else check("t4_n", 64'(log_q.size()), 64'd4);

        // Back-to-back frames, second one offset by 0x20.
        log_q.delete();
        done_cnt = 0;
        base_frame(0);
        send(NPIX, 1'b0);
        base_frame(32);
        send(NPIX, 1'b0);
        drain("t5");
        check("t5_n", 64'(log_q.size()), 64'd8);
        check("t5_done", 64'(done_cnt), 64'd2);
        if (log_q.size() == 8) begin
            check("t5_o4", 64'(log_q[4][7:0]), 64'h25);
            check("t5_o5", 64'(log_q[5][7:0]), 64'h27);
            check("t5_o6", 64'(log_q[6][7:0]), 64'h2D);
            check("t5_o7", 64'(log_q[7][7:0]), 64'h2F);
        end

        // Reset mid-frame after 6 beats.
        base_frame(0);
        send(6, 1'b0);
        repeat (2) idle();
        reset = 1'b0;
        #2;
        check("mid_rst_out", 64'(pixel_out), 64'd0);
        check("mid_rst_vld", 64'(pixel_out_valid), 64'd0);
        check("mid_rst_done", 64'(frame_done), 64'd0);
        repeat (2) idle();
        reset = 1'b1;
        log_q.delete();
        done_cnt = 0;
        send(NPIX, 1'b0);
        drain("t6");
        check("t6_n", 64'(log_q.size()), 64'd4);
        check("t6_done", 64'(done_cnt), 64'd1);
        if (log_q.size() == 4) begin
            check("t6_o0", 64'(log_q[0]), 64'(lit(5)));
            check("t6_o3", 64'(log_q[3]), 64'(lit(15)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
